// File: rtl/rtc_pkg.sv
// RTC bus sequencer shared definitions.
// Command codes, register map, access steps and per-command tables.
package rtc_pkg;

  localparam logic [2:0] CMD_RD_ALL   = 3'd1;
  localparam logic [2:0] CMD_WR_TIME  = 3'd2;
  localparam logic [2:0] CMD_WR_DATE  = 3'd3;
  localparam logic [2:0] CMD_WR_TIMER = 3'd4;
  localparam logic [2:0] CMD_WR_CTRL  = 3'd5;

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HR    = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MON   = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_TSEC  = 8'h41;
  localparam logic [7:0] ADDR_TMIN  = 8'h42;
  localparam logic [7:0] ADDR_THR   = 8'h43;
  localparam logic [7:0] ADDR_XTIME = 8'hF1;
  localparam logic [7:0] ADDR_XTMR  = 8'hF2;

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] RD_LEN = 4'd9;
  localparam logic [IDX_W-1:0] WR_LEN = 4'd4;

  typedef enum logic [2:0] {
    A_SET,
    A_STB,
    A_HLD,
    D_SET,
    D_STB,
    D_HLD,
    GAP
  } step_e;

  function automatic logic cmd_ok(
    input logic [2:0] c
  );
    return (c >= CMD_RD_ALL) &&
           (c <= CMD_WR_CTRL);
  endfunction

  function automatic logic [IDX_W-1:0]
    cmd_len(input logic [2:0] c);
    logic [IDX_W-1:0] n;
    n = '0;
    case (c)
      CMD_RD_ALL:   n = RD_LEN;
      CMD_WR_TIME:  n = WR_LEN;
      CMD_WR_DATE:  n = WR_LEN;
      CMD_WR_TIMER: n = WR_LEN;
      CMD_WR_CTRL:  n = 4'd1;
      default:      n = '0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] cmd_addr(
    input logic [2:0]       c,
    input logic [IDX_W-1:0] i
  );
    logic [7:0] a;
    a = ADDR_CTRL;
    case (c)
      CMD_RD_ALL: begin
        case (i)
          4'd0:    a = ADDR_SEC;
          4'd1:    a = ADDR_MIN;
          4'd2:    a = ADDR_HR;
          4'd3:    a = ADDR_DAY;
          4'd4:    a = ADDR_MON;
          4'd5:    a = ADDR_YEAR;
          4'd6:    a = ADDR_TSEC;
          4'd7:    a = ADDR_TMIN;
          4'd8:    a = ADDR_THR;
          default: a = ADDR_CTRL;
        endcase
      end
      CMD_WR_TIME: begin
        case (i)
          4'd0:    a = ADDR_SEC;
          4'd1:    a = ADDR_MIN;
          4'd2:    a = ADDR_HR;
          default: a = ADDR_XTIME;
        endcase
      end
      CMD_WR_DATE: begin
        case (i)
          4'd0:    a = ADDR_DAY;
          4'd1:    a = ADDR_MON;
          4'd2:    a = ADDR_YEAR;
          default: a = ADDR_XTIME;
        endcase
      end
      CMD_WR_TIMER: begin
        case (i)
          4'd0:    a = ADDR_TSEC;
          4'd1:    a = ADDR_TMIN;
          4'd2:    a = ADDR_THR;
          default: a = ADDR_XTMR;
        endcase
      end
      default: a = ADDR_CTRL;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// One multiplexed AD-bus access: address phase, data phase, gap.
// Pin outputs are registered from the next-state decode.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int T_STEP = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic [7:0] ad_in,
  output logic       ack,
  output logic [7:0] rdata,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n
);

  localparam int CW =
    (T_STEP > 1) ? $clog2(T_STEP) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'(T_STEP - 1);

  logic          active;
  step_e         step;
  logic [CW-1:0] cnt;
  logic [7:0]    a_reg;
  logic [7:0]    d_reg;
  logic          rw_reg;
  logic          last_cnt;

  logic          n_act;
  step_e         n_step;
  logic [CW-1:0] n_cnt;
  logic [7:0]    n_addr;
  logic [7:0]    n_data;
  logic          n_rw;

  logic [7:0]    o_out;
  logic          o_oe;
  logic          o_ad;
  logic          o_cs;
  logic          o_rd;
  logic          o_wr;

  // Step sequencing: each step holds for T_STEP cycles
  always_comb begin
    last_cnt = (cnt == CMAX);
    ack      = active && (step == GAP) &&
               last_cnt;
    n_act  = active;
    n_step = step;
    n_cnt  = cnt;
    n_addr = a_reg;
    n_data = d_reg;
    n_rw   = rw_reg;
    if (start) begin
      n_act  = 1'b1;
      n_step = A_SET;
      n_cnt  = '0;
      n_addr = addr;
      n_data = data;
      n_rw   = rw;
    end else if (active) begin
      if (last_cnt) begin
        n_cnt = '0;
        if (step == GAP) begin
          n_act  = 1'b0;
          n_step = A_SET;
        end else begin
          n_step = step_e'(step + 3'd1);
        end
      end else begin
        n_cnt = cnt + 1'b1;
      end
    end
  end

  // Pin decode for the step about to be entered
  always_comb begin
    o_out = 8'h00;
    o_oe  = 1'b0;
    o_ad  = 1'b1;
    o_cs  = 1'b1;
    o_rd  = 1'b1;
    o_wr  = 1'b1;
    if (n_act) begin
      unique case (n_step)
        A_SET, A_HLD: begin
          o_ad  = 1'b0;
          o_oe  = 1'b1;
          o_out = n_addr;
        end
        A_STB: begin
          o_ad  = 1'b0;
          o_oe  = 1'b1;
          o_out = n_addr;
          o_cs  = 1'b0;
          o_wr  = 1'b0;
        end
        D_SET, D_HLD: begin
          o_oe  = !n_rw;
          o_out = n_rw ? 8'h00 : n_data;
        end
        D_STB: begin
          o_oe  = !n_rw;
          o_out = n_rw ? 8'h00 : n_data;
          o_cs  = 1'b0;
          o_rd  = !n_rw;
          o_wr  = n_rw;
        end
        default: ;
      endcase
    end
  end

  // Step state, read capture and registered pins
  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      step   <= A_SET;
      cnt    <= '0;
      a_reg  <= 8'h00;
      d_reg  <= 8'h00;
      rw_reg <= 1'b0;
      rdata  <= 8'h00;
      ad_out <= 8'h00;
      ad_oe  <= 1'b0;
      a_d    <= 1'b1;
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
    end else begin
      active <= n_act;
      step   <= n_step;
      cnt    <= n_cnt;
      a_reg  <= n_addr;
      d_reg  <= n_data;
      rw_reg <= n_rw;
      if (active && rw_reg &&
          step == D_STB && last_cnt)
        rdata <= ad_in;
      ad_out <= o_out;
      ad_oe  <= o_oe;
      a_d    <= o_ad;
      cs_n   <= o_cs;
      rd_n   <= o_rd;
      wr_n   <= o_wr;
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// RTC transaction sequencer: turns one command into a list of bus
// accesses, holds operands and the read-back shadow registers.
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int T_STEP = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  input  logic [23:0] wr_time,
  input  logic [23:0] wr_date,
  input  logic [23:0] wr_timer,
  input  logic [7:0]  wr_ctrl,
  output logic        busy,
  output logic        done,
  output logic        cmd_drop,
  output logic [23:0] rd_time,
  output logic [23:0] rd_date,
  output logic [23:0] rd_timer,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  output logic        a_d,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n
);

  logic [2:0]       cmd_reg;
  logic [IDX_W-1:0] len;
  logic [IDX_W-1:0] idx;
  logic [23:0]      t_reg;
  logic [23:0]      d_reg;
  logic [23:0]      tm_reg;
  logic [7:0]       c_reg;
  logic [8:0][7:0]  shadow;
  logic [8:0][7:0]  shadow_nx;

  logic             accept;
  logic             ack;
  logic             last;
  logic             adv;
  logic             finish;
  logic             start;
  logic [2:0]       s_cmd;
  logic [IDX_W-1:0] s_idx;
  logic [23:0]      s_t;
  logic [23:0]      s_d;
  logic [23:0]      s_tm;
  logic [7:0]       s_c;
  logic [7:0]       s_addr;
  logic [7:0]       s_data;
  logic             s_rw;
  logic [7:0]       rdata;

  // Access selection: first access from live inputs, later from latches
  always_comb begin
    accept = cmd_valid && !busy &&
             cmd_ok(cmd);
    last   = (idx == len - 1'b1);
    adv    = busy && ack && !last;
    finish = busy && ack && last;
    start  = accept || adv;
    s_cmd  = accept ? cmd : cmd_reg;
    s_idx  = accept ? '0 : idx + 1'b1;
    s_t    = accept ? wr_time : t_reg;
    s_d    = accept ? wr_date : d_reg;
    s_tm   = accept ? wr_timer : tm_reg;
    s_c    = accept ? wr_ctrl : c_reg;
    s_addr = cmd_addr(s_cmd, s_idx);
    s_rw   = (s_cmd == CMD_RD_ALL);
    s_data = 8'h00;
    case (s_cmd)
      CMD_WR_TIME: begin
        case (s_idx)
          4'd0:    s_data = s_t[7:0];
          4'd1:    s_data = s_t[15:8];
          4'd2:    s_data = s_t[23:16];
          default: s_data = 8'h00;
        endcase
      end
      CMD_WR_DATE: begin
        case (s_idx)
          4'd0:    s_data = s_d[7:0];
          4'd1:    s_data = s_d[15:8];
          4'd2:    s_data = s_d[23:16];
          default: s_data = 8'h00;
        endcase
      end
      CMD_WR_TIMER: begin
        case (s_idx)
          4'd0:    s_data = s_tm[7:0];
          4'd1:    s_data = s_tm[15:8];
          4'd2:    s_data = s_tm[23:16];
          default: s_data = 8'h00;
        endcase
      end
      CMD_WR_CTRL: s_data = s_c;
      default:     s_data = 8'h00;
    endcase
    shadow_nx = shadow;
    if (busy && ack &&
        cmd_reg == CMD_RD_ALL)
      shadow_nx[idx] = rdata;
  end

  rtc_bus_cycle #(
    .T_STEP (T_STEP)
  ) u_cycle (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .rw     (s_rw),
    .addr   (s_addr),
    .data   (s_data),
    .ad_in  (ad_in),
    .ack    (ack),
    .rdata  (rdata),
    .ad_out (ad_out),
    .ad_oe  (ad_oe),
    .a_d    (a_d),
    .cs_n   (cs_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n)
  );

  // Command accept, access index, shadow and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cmd_drop <= 1'b0;
      cmd_reg  <= 3'd0;
      len      <= '0;
      idx      <= '0;
      t_reg    <= 24'h0;
      d_reg    <= 24'h0;
      tm_reg   <= 24'h0;
      c_reg    <= 8'h00;
      shadow   <= '0;
      rd_time  <= 24'h0;
      rd_date  <= 24'h0;
      rd_timer <= 24'h0;
    end else begin
      cmd_drop <= cmd_valid && !accept;
      done     <= finish;
      shadow   <= shadow_nx;
      if (accept) begin
        busy    <= 1'b1;
        cmd_reg <= cmd;
        len     <= cmd_len(cmd);
        idx     <= '0;
        t_reg   <= wr_time;
        d_reg   <= wr_date;
        tm_reg  <= wr_timer;
        c_reg   <= wr_ctrl;
      end else if (adv) begin
        idx <= idx + 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
      if (finish &&
          cmd_reg == CMD_RD_ALL) begin
        rd_time  <= {shadow_nx[2],
                     shadow_nx[1],
                     shadow_nx[0]};
        rd_date  <= {shadow_nx[5],
                     shadow_nx[4],
                     shadow_nx[3]};
        rd_timer <= {shadow_nx[8],
                     shadow_nx[7],
                     shadow_nx[6]};
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: bus model, access scoreboard and
// per-scenario checks on a T_STEP=2 and a T_STEP=1 instance.
module tb_rtc_bus_sequencer;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rd;
    logic       aoe;
    logic       doe;
    int         alen;
    int         dlen;
  } acc_t;

  logic        clock;
  logic        reset;
  logic [23:0] wr_time;
  logic [23:0] wr_date;
  logic [23:0] wr_timer;
  logic [7:0]  wr_ctrl;

  logic        cmd_valid2, cmd_valid1;
  logic [2:0]  cmd2, cmd1;
  logic        busy2, done2, cmd_drop2;
  logic        busy1, done1, cmd_drop1;
  logic [23:0] rd_time2, rd_date2, rd_timer2;
  logic [23:0] rd_time1, rd_date1, rd_timer1;
  logic [7:0]  ad_out2, ad_in2, alat2;
  logic [7:0]  ad_out1, ad_in1, alat1;
  logic        ad_oe2, a_d2, cs2_n, rd2_n, wr2_n;
  logic        ad_oe1, a_d1, cs1_n, rd1_n, wr1_n;

  int   n_cmp;
  int   n_bad;
  int   ovl;
  acc_t exp_q[$];
  acc_t obs[$];

  rtc_bus_sequencer #(.T_STEP(2)) dut2 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid2), .cmd(cmd2),
    .wr_time(wr_time), .wr_date(wr_date),
    .wr_timer(wr_timer), .wr_ctrl(wr_ctrl),
    .busy(busy2), .done(done2),
    .cmd_drop(cmd_drop2),
    .rd_time(rd_time2), .rd_date(rd_date2),
    .rd_timer(rd_timer2),
    .ad_out(ad_out2), .ad_oe(ad_oe2),
    .ad_in(ad_in2), .a_d(a_d2),
    .cs_n(cs2_n), .rd_n(rd2_n), .wr_n(wr2_n)
  );

  rtc_bus_sequencer #(.T_STEP(1)) dut1 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid1), .cmd(cmd1),
    .wr_time(wr_time), .wr_date(wr_date),
    .wr_timer(wr_timer), .wr_ctrl(wr_ctrl),
    .busy(busy1), .done(done1),
    .cmd_drop(cmd_drop1),
    .rd_time(rd_time1), .rd_date(rd_date1),
    .rd_timer(rd_timer1),
    .ad_out(ad_out1), .ad_oe(ad_oe1),
    .ad_in(ad_in1), .a_d(a_d1),
    .cs_n(cs1_n), .rd_n(rd1_n), .wr_n(wr1_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RTC model: latch address on address strobe, return addr ^ A5
  always @(posedge clock) begin
    if (!cs2_n && !a_d2) alat2 <= ad_out2;
    if (!cs1_n && !a_d1) alat1 <= ad_out1;
  end
  assign ad_in2 = alat2 ^ 8'hA5;
  assign ad_in1 = alat1 ^ 8'hA5;

  // Monitor: assemble observed dut2 accesses, count strobe overlap
  initial begin
    acc_t cur;
    bit   pa, pd, sa, sd;
    pa = 0;
    pd = 0;
    cur = '{addr:0, data:0, rd:0, aoe:0,
            doe:0, alen:0, dlen:0};
    forever begin
      @(negedge clock);
      if (reset) begin
        pa = 0;
        pd = 0;
      end else begin
        if (!rd2_n && !wr2_n) ovl++;
        if (!rd1_n && !wr1_n) ovl++;
        sa = !cs2_n && !a_d2;
        sd = !cs2_n && a_d2;
        if (sa) begin
          if (!pa) begin
            cur.addr = ad_out2;
            cur.aoe  = ad_oe2;
            cur.alen = 0;
          end
          cur.alen++;
        end
        if (sd) begin
          if (!pd) begin
            cur.rd   = !rd2_n;
            cur.data = !rd2_n ? ad_in2 : ad_out2;
            cur.doe  = ad_oe2;
            cur.dlen = 0;
          end
          cur.dlen++;
        end
        if (pd && !sd) obs.push_back(cur);
        pa = sa;
        pd = sd;
      end
    end
  end

  task automatic push_exp(
    input logic [7:0] a,
    input logic [7:0] d,
    input logic       r
  );
    exp_q.push_back('{addr:a, data:d, rd:r,
                      aoe:1'b1, doe:!r,
                      alen:2, dlen:2});
  endtask

  task automatic issue2(input logic [2:0] c);
    @(negedge clock);
    cmd_valid2 = 1'b1;
    cmd2 = c;
    @(negedge clock);
    cmd_valid2 = 1'b0;
    cmd2 = 3'd0;
  endtask

  task automatic test_reset;
    int bad;
    n_cmp++;
    if ({busy2, done2, cmd_drop2, rd_time2,
         rd_date2, rd_timer2, ad_out2, ad_oe2,
         a_d2, cs2_n, rd2_n, wr2_n} !==
        {3'b000, 72'h0, 8'h00, 5'b01111}) begin
      n_bad++;
      $display("FAIL reset2: got %b/%h/%h/%b",
               {busy2, done2, cmd_drop2},
               {rd_time2, rd_date2, rd_timer2},
               ad_out2,
               {ad_oe2, a_d2, cs2_n, rd2_n, wr2_n});
    end
    n_cmp++;
    if ({busy1, done1, cmd_drop1, rd_time1,
         rd_date1, rd_timer1, ad_out1, ad_oe1,
         a_d1, cs1_n, rd1_n, wr1_n} !==
        {3'b000, 72'h0, 8'h00, 5'b01111}) begin
      n_bad++;
      $display("FAIL reset1: got %b/%h/%b",
               {busy1, done1, cmd_drop1}, ad_out1,
               {ad_oe1, a_d1, cs1_n, rd1_n, wr1_n});
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if ({busy2, ad_oe2, a_d2, cs2_n, rd2_n,
           wr2_n} !== 6'b001111)
        bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL idle: %0d non-idle cycles, want 0",
               bad);
    end
  endtask

  task automatic test_wr_time;
    int   cnt;
    acc_t e, o;
    push_exp(8'h21, 8'h56, 1'b0);
    push_exp(8'h22, 8'h34, 1'b0);
    push_exp(8'h23, 8'h12, 1'b0);
    push_exp(8'hF1, 8'h00, 1'b0);
    wr_time = 24'h123456;
    issue2(3'd2);
    wr_time = 24'h999999;
    cnt = 0;
    while (busy2 && cnt < 2000) begin
      cnt++;
      @(negedge clock);
    end
    n_cmp++;
    if ({cnt, done2} !== {32'd56, 1'b1}) begin
      n_bad++;
      $display("FAIL wt_busy: got %0d done=%b want 56 done=1",
               cnt, done2);
    end
    @(negedge clock);
    n_cmp++;
    if (done2 !== 1'b0) begin
      n_bad++;
      $display("FAIL wt_pulse: done got %b want 0", done2);
    end
    n_cmp++;
    if (obs.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL wt_count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front();
      o = obs.pop_front();
      n_cmp++;
      if ({o.addr, o.data, o.rd, o.aoe, o.doe} !==
          {e.addr, e.data, e.rd, e.aoe, e.doe} ||
          o.alen != e.alen || o.dlen != e.dlen) begin
        n_bad++;
        $display("FAIL wt_acc: got %h/%h r%b oe%b%b len%0d/%0d want %h/%h r%b len%0d",
                 o.addr, o.data, o.rd, o.aoe, o.doe,
                 o.alen, o.dlen, e.addr, e.data,
                 e.rd, e.alen);
      end
    end
    exp_q.delete();
    obs.delete();
  endtask

  task automatic test_rd_all;
    int          cnt, chg;
    acc_t        e, o;
    logic [7:0]  ra [9];
    logic [23:0] et, ed, etm;
    ra = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
           8'h26, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 9; i++)
      push_exp(ra[i], ra[i] ^ 8'hA5, 1'b1);
    et  = {ra[2] ^ 8'hA5, ra[1] ^ 8'hA5,
           ra[0] ^ 8'hA5};
    ed  = {ra[5] ^ 8'hA5, ra[4] ^ 8'hA5,
           ra[3] ^ 8'hA5};
    etm = {ra[8] ^ 8'hA5, ra[7] ^ 8'hA5,
           ra[6] ^ 8'hA5};
    issue2(3'd1);
    cnt = 0;
    chg = 0;
    while (busy2 && cnt < 2000) begin
      if ({rd_time2, rd_date2, rd_timer2} !== 72'h0)
        chg++;
      cnt++;
      @(negedge clock);
    end
    n_cmp++;
    if ({cnt, done2} !== {32'd126, 1'b1}) begin
      n_bad++;
      $display("FAIL rd_busy: got %0d done=%b want 126 done=1",
               cnt, done2);
    end
    n_cmp++;
    if (chg !== 0) begin
      n_bad++;
      $display("FAIL rd_early: %0d cycles changed, want 0",
               chg);
    end
    n_cmp++;
    if ({rd_time2, rd_date2, rd_timer2} !==
        {et, ed, etm}) begin
      n_bad++;
      $display("FAIL rd_vals: got %h %h %h want %h %h %h",
               rd_time2, rd_date2, rd_timer2,
               et, ed, etm);
    end
    n_cmp++;
    if (obs.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL rd_count: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front();
      o = obs.pop_front();
      n_cmp++;
      if ({o.addr, o.data, o.rd, o.aoe, o.doe} !==
          {e.addr, e.data, e.rd, e.aoe, e.doe} ||
          o.alen != e.alen || o.dlen != e.dlen) begin
        n_bad++;
        $display("FAIL rd_acc: got %h/%h r%b oe%b%b len%0d/%0d want %h/%h r%b",
                 o.addr, o.data, o.rd, o.aoe, o.doe,
                 o.alen, o.dlen, e.addr, e.data, e.rd);
      end
    end
    exp_q.delete();
    obs.delete();
  endtask

  task automatic test_drop;
    int         cnt;
    acc_t       e, o;
    logic [2:0] bad_codes [3];
    bad_codes = '{3'd0, 3'd6, 3'd7};
    wr_ctrl = 8'hC3;
    push_exp(8'h00, 8'hC3, 1'b0);
    issue2(3'd5);
    cmd_valid2 = 1'b1;
    cmd2 = 3'd2;
    @(negedge clock);
    cmd_valid2 = 1'b0;
    cmd2 = 3'd0;
    n_cmp++;
    if ({cmd_drop2, busy2} !== 2'b11) begin
      n_bad++;
      $display("FAIL drop_busy: drop/busy got %b want 11",
               {cmd_drop2, busy2});
    end
    cnt = 1;
    while (busy2 && cnt < 2000) begin
      cnt++;
      @(negedge clock);
    end
    n_cmp++;
    if ({cnt, done2} !== {32'd14, 1'b1}) begin
      n_bad++;
      $display("FAIL drop_len: got %0d done=%b want 14 done=1",
               cnt, done2);
    end
    n_cmp++;
    if (obs.size() !== 1) begin
      n_bad++;
      $display("FAIL drop_count: got %0d want 1",
               obs.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front();
      o = obs.pop_front();
      n_cmp++;
      if ({o.addr, o.data, o.rd} !==
          {e.addr, e.data, e.rd}) begin
        n_bad++;
        $display("FAIL drop_acc: got %h/%h r%b want %h/%h r%b",
                 o.addr, o.data, o.rd,
                 e.addr, e.data, e.rd);
      end
    end
    exp_q.delete();
    obs.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      cmd_valid2 = 1'b1;
      cmd2 = bad_codes[i];
      @(negedge clock);
      cmd_valid2 = 1'b0;
      cmd2 = 3'd0;
      n_cmp++;
      if ({cmd_drop2, busy2} !== 2'b10) begin
        n_bad++;
        $display("FAIL drop_code%0d: drop/busy got %b want 10",
                 bad_codes[i], {cmd_drop2, busy2});
      end
    end
  endtask

  task automatic test_reset_mid;
    int dn;
    wr_date = 24'h250611;
    issue2(3'd3);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({cs2_n, wr2_n, rd2_n, ad_oe2, a_d2,
         busy2, done2} !== 7'b1110100) begin
      n_bad++;
      $display("FAIL rst_mid: got %b want 1110100",
               {cs2_n, wr2_n, rd2_n, ad_oe2, a_d2,
                busy2, done2});
    end
    n_cmp++;
    if ({rd_time2, rd_date2, rd_timer2} !== 72'h0) begin
      n_bad++;
      $display("FAIL rst_rd: got %h %h %h want 0",
               rd_time2, rd_date2, rd_timer2);
    end
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done2 || busy2) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin
      n_bad++;
      $display("FAIL rst_done: %0d busy/done cycles, want 0",
               dn);
    end
    exp_q.delete();
    obs.delete();
  endtask

  task automatic test_back_to_back;
    int          cnt;
    logic [12:0] pins;
    logic [23:0] ed;
    ed = {8'h26 ^ 8'hA5, 8'h25 ^ 8'hA5,
          8'h24 ^ 8'hA5};
    wr_ctrl = 8'h5A;
    @(negedge clock);
    cmd_valid1 = 1'b1;
    cmd1 = 3'd5;
    @(negedge clock);
    cmd_valid1 = 1'b0;
    cmd1 = 3'd0;
    wr_ctrl = 8'h00;
    cnt = 0;
    while (busy1 && cnt < 100) begin
      pins = {cs1_n, wr1_n, rd1_n, a_d1,
              ad_oe1, ad_out1};
      if (cnt == 1) begin
        n_cmp++;
        if (pins !== {5'b00101, 8'h00}) begin
          n_bad++;
          $display("FAIL b2b_astb: got %h want %h",
                   pins, {5'b00101, 8'h00});
        end
      end
      if (cnt == 4) begin
        n_cmp++;
        if (pins !== {5'b00111, 8'h5A}) begin
          n_bad++;
          $display("FAIL b2b_dstb: got %h want %h",
                   pins, {5'b00111, 8'h5A});
        end
      end
      if (cnt == 6) begin
        n_cmp++;
        if (pins !== {5'b11110, 8'h00}) begin
          n_bad++;
          $display("FAIL b2b_gap: got %h want %h",
                   pins, {5'b11110, 8'h00});
        end
      end
      cnt++;
      @(negedge clock);
    end
    n_cmp++;
    if ({cnt, done1} !== {32'd7, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_len: got %0d done=%b want 7 done=1",
               cnt, done1);
    end
    cmd_valid1 = 1'b1;
    cmd1 = 3'd1;
    @(negedge clock);
    cmd_valid1 = 1'b0;
    cmd1 = 3'd0;
    n_cmp++;
    if ({busy1, cmd_drop1} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_accept: busy/drop got %b want 10",
               {busy1, cmd_drop1});
    end
    cnt = 0;
    while (busy1 && cnt < 500) begin
      cnt++;
      @(negedge clock);
    end
    n_cmp++;
    if ({cnt, done1, rd_date1} !==
        {32'd63, 1'b1, ed}) begin
      n_bad++;
      $display("FAIL b2b_rd: got %0d done=%b date=%h want 63 1 %h",
               cnt, done1, rd_date1, ed);
    end
    n_cmp++;
    if (ovl !== 0) begin
      n_bad++;
      $display("FAIL strobe_excl: %0d overlaps, want 0",
               ovl);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ovl = 0;
    reset = 1'b1;
    cmd_valid2 = 1'b0;
    cmd_valid1 = 1'b0;
    cmd2 = 3'd0;
    cmd1 = 3'd0;
    wr_time = 24'h0;
    wr_date = 24'h0;
    wr_timer = 24'h0;
    wr_ctrl = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_wr_time();
    test_rd_all();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
